// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS core front end.
//   RESET_PC / INT_VECTOR / EXC_VECTOR : kernel-mode vectors (words 0/1/2)
//   NOP_INSTR                          : bubble instruction (sll $0,$0,0)
//   npc_sel_e                          : next-PC source, highest priority first
package cpu_pkg;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] INT_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JR   = 3'd2,
    SEL_J    = 3'd3,
    SEL_HOLD = 3'd4,
    SEL_INT  = 3'd5,
    SEL_SEQ  = 3'd6
  } npc_sel_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n   : clock, async active-low reset
//   hold         : keep current contents (load-use stall)
//   flush        : load a bubble (NOP, valid=0) but still track PC+4
//   instr_in     : fetched instruction
//   pcplus4_in   : PC+4 of the fetched instruction
//   instr/pcplus4/valid : registered outputs to decode
module if_id_reg #(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pcplus4_in,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        valid
);

  // Flush beats hold: a redirect always squashes, even under a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= NOP;
      pcplus4 <= 32'd0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= NOP;
      pcplus4 <= pcplus4_in;
      valid   <= 1'b0;
    end else if (!hold) begin
      instr   <= instr_in;
      pcplus4 <= pcplus4_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC priority, interrupt and
// exception vectoring, IF/ID register.
//   clk, reset         : clock, async active-low reset
//   Instruction        : imem word for Address (same cycle)
//   Stall              : hold PC and IF/ID
//   BranchTaken/Target : EX-resolved branch
//   Jump/JumpTarget    : j/jal from ID (instr_index)
//   JrTaken/JrAddr     : jr/jalr from ID
//   IRQ                : level interrupt request
//   Exception          : undefined-instruction pulse from ID
//   Address            : PC to imem
//   IF_ID_*            : IF/ID register outputs
//   EPC, EPC_We        : return address and its one-cycle load strobe
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] INT_VECTOR = cpu_pkg::INT_VECTOR,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpTarget,
  input  logic        JrTaken,
  input  logic [31:0] JrAddr,
  input  logic        IRQ,
  input  logic        Exception,
  output logic [31:0] Address,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] EPC,
  output logic        EPC_We
);
  import cpu_pkg::*;

  logic [31:0] pc, pc_plus4, jump_addr, pc_next;
  logic        irq_pending, irq_eff;
  logic        flush, hold;
  npc_sel_e    sel;

  assign Address   = pc;
  assign pc_plus4  = pc + 32'd4;
  assign jump_addr = {IF_ID_PCPlus4[31:28], JumpTarget, 2'b00};

  // A request seen this cycle is already eligible, so a one-cycle IRQ
  // pulse in user mode is taken immediately.
  assign irq_eff = irq_pending | IRQ;

  // Redirects keep the current privilege bit; only the vectors and a
  // kernel-mode jr may set PC[31].
  always_comb begin
    sel = SEL_SEQ;
    if (Exception)                  sel = SEL_EXC;
    else if (BranchTaken)           sel = SEL_BR;
    else if (JrTaken)               sel = SEL_JR;
    else if (Jump)                  sel = SEL_J;
    else if (Stall)                 sel = SEL_HOLD;
    else if (irq_eff && !pc[31])    sel = SEL_INT;
  end

  always_comb begin
    pc_next = pc_plus4;
    case (sel)
      SEL_EXC:  pc_next = EXC_VECTOR;
      SEL_BR:   pc_next = {pc[31], BranchTarget[30:0]};
      SEL_JR:   pc_next = pc[31] ? JrAddr : {1'b0, JrAddr[30:0]};
      SEL_J:    pc_next = {pc[31], jump_addr[30:0]};
      SEL_HOLD: pc_next = pc;
      SEL_INT:  pc_next = INT_VECTOR;
      default:  pc_next = pc_plus4;
    endcase
  end

  assign hold  = (sel == SEL_HOLD);
  assign flush = (sel == SEL_EXC) || (sel == SEL_BR) || (sel == SEL_JR) ||
                 (sel == SEL_J)   || (sel == SEL_INT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      irq_pending <= 1'b0;
      EPC         <= 32'd0;
      EPC_We      <= 1'b0;
    end else begin
      pc          <= pc_next;
      irq_pending <= (sel == SEL_INT) ? 1'b0 : irq_eff;
      EPC_We      <= (sel == SEL_EXC) || (sel == SEL_INT);
      if (sel == SEL_EXC)
        EPC <= IF_ID_PCPlus4 - 32'd4;   // faulting instruction sits in ID
      else if (sel == SEL_INT)
        EPC <= pc;                      // squashed IF instruction restarts
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (reset),
    .hold       (hold),
    .flush      (flush),
    .instr_in   (Instruction),
    .pcplus4_in (pc_plus4),
    .instr      (IF_ID_Instruction),
    .pcplus4    (IF_ID_PCPlus4),
    .valid      (IF_ID_Valid)
  );

  // Bit 31 of the branch target and jump address is replaced by the
  // current privilege bit.
  logic unused_bits;
  assign unused_bits = BranchTarget[31] ^ jump_addr[31];

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction;
  logic        Stall, BranchTaken, Jump, JrTaken, IRQ, Exception;
  logic [31:0] BranchTarget, JrAddr;
  logic [25:0] JumpTarget;
  logic [31:0] Address, IF_ID_Instruction, IF_ID_PCPlus4, EPC;
  logic        IF_ID_Valid, EPC_We;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Jump(Jump),
    .JumpTarget(JumpTarget), .JrTaken(JrTaken), .JrAddr(JrAddr), .IRQ(IRQ),
    .Exception(Exception), .Address(Address),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .EPC(EPC), .EPC_We(EPC_We)
  );

  typedef struct {
    logic [31:0] instr;
    logic        stall, br;
    logic [31:0] brt;
    logic        j;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] jra;
    logic        irq, exc;
    logic [31:0] e_addr, e_ii, e_ip4;
    logic        e_iv;
    logic [31:0] e_epc;
    logic        e_we;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic [31:0] instr, input logic stall, input logic br,
      input logic [31:0] brt, input logic j, input logic [25:0] jt,
      input logic jr, input logic [31:0] jra, input logic irq, input logic exc,
      input logic [31:0] e_addr, input logic [31:0] e_ii, input logic [31:0] e_ip4,
      input logic e_iv, input logic [31:0] e_epc, input logic e_we);
    vec_t v;
    v.instr = instr; v.stall = stall; v.br = br; v.brt = brt; v.j = j;
    v.jt = jt; v.jr = jr; v.jra = jra; v.irq = irq; v.exc = exc;
    v.e_addr = e_addr; v.e_ii = e_ii; v.e_ip4 = e_ip4; v.e_iv = e_iv;
    v.e_epc = e_epc; v.e_we = e_we;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] ii,
                         input logic [31:0] ip4, input logic iv, input logic [31:0] epc,
                         input logic we);
    chk({tag, ".Address"}, Address, a);
    chk({tag, ".IF_ID_Instruction"}, IF_ID_Instruction, ii);
    chk({tag, ".IF_ID_PCPlus4"}, IF_ID_PCPlus4, ip4);
    chk({tag, ".IF_ID_Valid"}, {31'd0, IF_ID_Valid}, {31'd0, iv});
    chk({tag, ".EPC"}, EPC, epc);
    chk({tag, ".EPC_We"}, {31'd0, EPC_We}, {31'd0, we});
  endtask

  task automatic idle_inputs();
    Instruction = 32'd0; Stall = 0; BranchTaken = 0; BranchTarget = 32'd0;
    Jump = 0; JumpTarget = 26'd0; JrTaken = 0; JrAddr = 32'd0; IRQ = 0; Exception = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference model state (architectural view)
  logic [31:0] m_pc, m_ii, m_ip4, m_epc;
  logic        m_iv, m_we, m_pend;

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_ii = 32'd0; m_ip4 = 32'd0; m_iv = 0;
    m_epc = 32'd0; m_we = 0; m_pend = 0;
  endtask

  // Next state from the current inputs, following the priority rules.
  task automatic model_step();
    logic pend;
    logic [31:0] ja;
    pend = m_pend | IRQ;
    ja = {m_ip4[31:28], JumpTarget, 2'b00};
    m_we = 0;
    if (Exception || BranchTaken || JrTaken || Jump) begin
      m_ii = 32'd0; m_iv = 0;
      m_ip4 = m_pc + 32'd4;
      if (Exception) begin
        m_epc = m_ip4_prev_minus4(); m_we = 1; m_pc = 32'h8000_0008;
      end else if (BranchTaken) m_pc = {m_pc[31], BranchTarget[30:0]};
      else if (JrTaken)         m_pc = m_pc[31] ? JrAddr : {1'b0, JrAddr[30:0]};
      else                      m_pc = {m_pc[31], ja[30:0]};
      m_pend = pend;
    end else if (Stall) begin
      m_pend = pend;
    end else if (pend && !m_pc[31]) begin
      m_epc = m_pc; m_we = 1;
      m_ii = 32'd0; m_iv = 0; m_ip4 = m_pc + 32'd4;
      m_pc = 32'h8000_0004;
      m_pend = 0;
    end else begin
      m_ii = Instruction; m_iv = 1; m_ip4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_pend = pend;
    end
  endtask

  // IF_ID_PCPlus4 before this cycle's update; captured ahead of model_step.
  logic [31:0] m_ip4_saved;
  function automatic logic [31:0] m_ip4_prev_minus4();
    return m_ip4_saved - 32'd4;
  endfunction

  initial begin
    idle_inputs();
    reset = 0;
    #12;
    chk_all("reset", 32'h8000_0000, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk); reset = 1;
    #4; // just past the following posedge? no: wait for the edge explicitly
    chk_all("release_hold", 32'h8000_0000, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    //           instr         st br brt           j  jt     jr jra           irq exc  addr          ii            ip4           iv epc           we
    vecs.push_back(mk(32'h0800_0003,0,0,32'h0,      0,26'h0,0,32'h0,        0,0, 32'h8000_0004,32'h0800_0003,32'h8000_0004,1,32'h0,       0));
    vecs.push_back(mk(32'h11,      0,0,32'h0,       1,26'h3,0,32'h0,        0,0, 32'h8000_000C,32'h0,       32'h8000_0008,0,32'h0,       0));
    vecs.push_back(mk(32'h12,      0,0,32'h0,       0,26'h0,1,32'h30,       0,0, 32'h30,       32'h0,       32'h8000_0010,0,32'h0,       0));
    vecs.push_back(mk(32'h22,      0,0,32'h0,       0,26'h0,0,32'h0,        0,0, 32'h34,       32'h22,      32'h34,       1,32'h0,       0));
    vecs.push_back(mk(32'h23,      1,1,32'h100,     0,26'h0,0,32'h0,        0,0, 32'h100,      32'h0,       32'h38,       0,32'h0,       0));
    vecs.push_back(mk(32'h33,      0,0,32'h0,       0,26'h0,0,32'h0,        0,0, 32'h104,      32'h33,      32'h104,      1,32'h0,       0));
    vecs.push_back(mk(32'h44,      1,0,32'h0,       0,26'h0,0,32'h0,        0,0, 32'h104,      32'h33,      32'h104,      1,32'h0,       0));
    vecs.push_back(mk(32'h45,      0,0,32'h0,       0,26'h0,1,32'h8000_0000,0,0, 32'h0,        32'h0,       32'h108,      0,32'h0,       0));
    vecs.push_back(mk(32'h55,      0,0,32'h0,       0,26'h0,0,32'h0,        0,0, 32'h4,        32'h55,      32'h4,        1,32'h0,       0));
    vecs.push_back(mk(32'h66,      0,0,32'h0,       0,26'h0,0,32'h0,        1,0, 32'h8000_0004,32'h0,       32'h8,        0,32'h4,       1));
    vecs.push_back(mk(32'h77,      0,0,32'h0,       0,26'h0,0,32'h0,        0,0, 32'h8000_0008,32'h77,      32'h8000_0008,1,32'h4,       0));
    vecs.push_back(mk(32'h88,      0,0,32'h0,       0,26'h0,0,32'h0,        0,1, 32'h8000_0008,32'h0,       32'h8000_000C,0,32'h8000_0004,1));
    vecs.push_back(mk(32'h0,       0,0,32'h0,       0,26'h0,0,32'h0,        1,1, 32'h8000_0008,32'h0,       32'h8000_000C,0,32'h8000_0008,1));
    vecs.push_back(mk(32'h0,       0,0,32'h0,       0,26'h0,1,32'h200,      0,0, 32'h200,      32'h0,       32'h8000_000C,0,32'h8000_0008,0));
    vecs.push_back(mk(32'h99,      0,0,32'h0,       0,26'h0,0,32'h0,        0,0, 32'h8000_0004,32'h0,       32'h204,      0,32'h200,     1));
    vecs.push_back(mk(32'hAA,      0,0,32'h0,       0,26'h0,0,32'h0,        0,0, 32'h8000_0008,32'hAA,      32'h8000_0008,1,32'h200,     0));
    vecs.push_back(mk(32'hBB,      0,1,32'h50,      0,26'h0,0,32'h0,        0,0, 32'h8000_0050,32'h0,       32'h8000_000C,0,32'h200,     0));

    for (int i = 0; i < vecs.size(); i++) begin
      Instruction = vecs[i].instr; Stall = vecs[i].stall; BranchTaken = vecs[i].br;
      BranchTarget = vecs[i].brt; Jump = vecs[i].j; JumpTarget = vecs[i].jt;
      JrTaken = vecs[i].jr; JrAddr = vecs[i].jra; IRQ = vecs[i].irq; Exception = vecs[i].exc;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_ii, vecs[i].e_ip4,
              vecs[i].e_iv, vecs[i].e_epc, vecs[i].e_we);
    end

    // Async reset in the middle of a stall with an interrupt pending.
    idle_inputs();
    JrTaken = 1; JrAddr = 32'h300;
    step();
    chk("mid.jr_user", Address, 32'h300);
    idle_inputs();
    Stall = 1; IRQ = 1;
    step();
    chk("mid.stalled", Address, 32'h300);
    IRQ = 0;
    #2 reset = 0;
    #1;
    chk_all("mid.async", 32'h8000_0000, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk); reset = 1; Stall = 0;
    step();
    chk("mid.rel0", Address, 32'h8000_0004);
    step();
    chk("mid.rel1", Address, 32'h8000_0008);
    JrTaken = 1; JrAddr = 32'h40;
    step();
    chk("mid.to_user", Address, 32'h40);
    JrTaken = 0;
    step();
    chk("mid.no_int", Address, 32'h44);
    chk("mid.no_epcwe", {31'd0, EPC_We}, 32'd0);

    // Randomized run against the reference model, with occasional resets.
    idle_inputs();
    reset = 0; #2;
    model_reset();
    chk_all("rnd.reset", m_pc, m_ii, m_ip4, m_iv, m_epc, m_we);
    @(negedge clk); reset = 1;
    step();
    model_step_seq_after_release();
    for (int c = 0; c < 3000; c++) begin
      Instruction  = $urandom;
      Stall        = ($urandom_range(0, 99) < 15);
      BranchTaken  = ($urandom_range(0, 99) < 6);
      BranchTarget = $urandom;
      Jump         = ($urandom_range(0, 99) < 6);
      JumpTarget   = 26'($urandom);
      JrTaken      = ($urandom_range(0, 99) < 8);
      JrAddr       = $urandom;
      IRQ          = ($urandom_range(0, 99) < 10);
      Exception    = ($urandom_range(0, 99) < 4);
      m_ip4_saved  = m_ip4;
      model_step();
      step();
      chk_all("rnd", m_pc, m_ii, m_ip4, m_iv, m_epc, m_we);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 0; #1;
        model_reset();
        chk_all("rnd.areset", m_pc, m_ii, m_ip4, m_iv, m_epc, m_we);
        @(negedge clk); reset = 1;
        idle_inputs();
        m_ip4_saved = m_ip4;
        model_step();
        step();
        chk_all("rnd.release", m_pc, m_ii, m_ip4, m_iv, m_epc, m_we);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // First edge after the random-phase reset release ran with idle inputs.
  task automatic model_step_seq_after_release();
    m_ip4_saved = m_ip4;
    model_step();
    chk_all("rnd.first", m_pc, m_ii, m_ip4, m_iv, m_epc, m_we);
  endtask

endmodule
